// File: rtl/jtkcpu_muldiv_pkg.sv
// ----------------------------------------------------------------------------
// jtkcpu_muldiv_pkg: op encodings and CC bit indices shared with the sequencer.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package jtkcpu_muldiv_pkg;

  localparam logic [1:0] MD_MULU = 2'd0;
  localparam logic [1:0] MD_MULS = 2'd1;
  localparam logic [1:0] MD_DIVU = 2'd2;
  localparam logic [1:0] MD_DIVS = 2'd3;

  localparam int CC_C = 0;
  localparam int CC_V = 1;
  localparam int CC_Z = 2;
  localparam int CC_N = 3;

endpackage

`default_nettype wire

// File: rtl/jtkcpu_negabs.sv
// ----------------------------------------------------------------------------
// jtkcpu_negabs: combinational conditional two's-complement negate.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module jtkcpu_negabs #(
  parameter int W = 16
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? ((~val_i) + W'(1)) : val_i;

endmodule

`default_nettype wire

// File: rtl/jtkcpu_muldiv.sv
// ----------------------------------------------------------------------------
// jtkcpu_muldiv: multi-cycle shift-add multiply / restoring divide, one bit
// per enabled clock, with start/busy/done handshake.  Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module jtkcpu_muldiv
  import jtkcpu_muldiv_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] opnd0,
  input  logic [W-1:0] opnd1,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rslt_hi,
  output logic [W-1:0] rslt_lo,
  output logic         c_out,
  output logic         v_out,
  output logic         z_out,
  output logic         n_out
);

  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  state_t          state_q;
  logic [1:0]      op_q;
  logic [W-1:0]    op0_q;
  logic [W-1:0]    op1_q;
  logic [W-1:0]    oth_q;
  logic [2*W-1:0]  acc_q;
  logic [2*W-1:0]  acc_d;
  logic [CW-1:0]   cnt_q;
  logic            neg_q;
  logic            rneg_q;
  logic            dz_q;
  logic            ovf_q;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    hi_q;
  logic [W-1:0]    lo_q;
  logic [3:0]      cc_q;

  logic            is_div;
  logic            is_signed;
  logic [W-1:0]    abs0;
  logic [W-1:0]    abs1;
  logic [W:0]      mul_sum;
  logic [W:0]      div_shift;
  logic [W:0]      div_diff;
  logic            qbit;
  logic [2*W-1:0]  fix_prod;
  logic [W-1:0]    fix_quo;
  logic [W-1:0]    fix_rem;

  assign is_div    = (op_q == MD_DIVU) || (op_q == MD_DIVS);
  assign is_signed = (op_q == MD_MULS) || (op_q == MD_DIVS);

  jtkcpu_negabs #(.W(W)) u_abs0 (
    .val_i (op0_q),
    .neg_i (is_signed & op0_q[W-1]),
    .res_o (abs0)
  );

  jtkcpu_negabs #(.W(W)) u_abs1 (
    .val_i (op1_q),
    .neg_i (is_signed & op1_q[W-1]),
    .res_o (abs1)
  );

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB then shift right.
  assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, oth_q} : {(W+1){1'b0}});

  // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
  assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff  = div_shift - {1'b0, oth_q};
  assign qbit      = ~div_diff[W];

  always_comb begin
    acc_d = {mul_sum, acc_q[W-1:1]};
    if (is_div) begin
      acc_d = {(qbit ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], qbit};
    end
  end

  jtkcpu_negabs #(.W(2*W)) u_fix_prod (
    .val_i (acc_q),
    .neg_i (neg_q),
    .res_o (fix_prod)
  );

  jtkcpu_negabs #(.W(W)) u_fix_quo (
    .val_i (acc_q[W-1:0]),
    .neg_i (neg_q),
    .res_o (fix_quo)
  );

  jtkcpu_negabs #(.W(W)) u_fix_rem (
    .val_i (acc_q[2*W-1:W]),
    .neg_i (rneg_q),
    .res_o (fix_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 2'd0;
      op0_q   <= '0;
      op1_q   <= '0;
      oth_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cc_q    <= 4'd0;
    end else if (cen) begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            op0_q   <= opnd0;
            op1_q   <= opnd1;
            busy_q  <= 1'b1;
            state_q <= ST_PREP;
          end
        end
        ST_PREP: begin
          cnt_q  <= CW'(W);
          neg_q  <= is_signed & (op0_q[W-1] ^ op1_q[W-1]);
          rneg_q <= is_signed & is_div & op0_q[W-1];
          dz_q   <= is_div && (op1_q == '0);
          ovf_q  <= (op_q == MD_DIVS) && (op0_q == MOST_NEG) && (op1_q == '1);
          if (is_div) begin
            oth_q <= abs1;
            acc_q <= {{W{1'b0}}, abs0};
          end else begin
            oth_q <= abs0;
            acc_q <= {{W{1'b0}}, abs1};
          end
          state_q <= (is_div && (op1_q == '0)) ? ST_FIX : ST_RUN;
        end
        ST_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          cc_q <= 4'd0;
          if (dz_q) begin
            hi_q       <= op0_q;
            lo_q       <= '1;
            cc_q[CC_V] <= 1'b1;
            cc_q[CC_N] <= 1'b1;
          end else if (!is_div) begin
            hi_q       <= fix_prod[2*W-1:W];
            lo_q       <= fix_prod[W-1:0];
            cc_q[CC_C] <= fix_prod[W-1];
            cc_q[CC_N] <= fix_prod[2*W-1];
            cc_q[CC_Z] <= (fix_prod == '0);
          end else begin
            // MOST_NEG / -1 yields MOST_NEG with zero remainder naturally.
            hi_q       <= fix_rem;
            lo_q       <= fix_quo;
            cc_q[CC_Z] <= (fix_quo == '0);
            cc_q[CC_N] <= fix_quo[W-1];
            cc_q[CC_V] <= ovf_q;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rslt_hi = hi_q;
  assign rslt_lo = lo_q;
  assign c_out   = cc_q[CC_C];
  assign v_out   = cc_q[CC_V];
  assign z_out   = cc_q[CC_Z];
  assign n_out   = cc_q[CC_N];

endmodule

`default_nettype wire

// File: tb/tb_jtkcpu_muldiv.sv
// ----------------------------------------------------------------------------
// tb_jtkcpu_muldiv: self-checking bench for jtkcpu_muldiv (W=16).
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_jtkcpu_muldiv;
  import jtkcpu_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic        start;
  logic [1:0]  op;
  logic [15:0] opnd0;
  logic [15:0] opnd1;
  logic        busy;
  logic        done;
  logic [15:0] rslt_hi;
  logic [15:0] rslt_lo;
  logic        c_out;
  logic        v_out;
  logic        z_out;
  logic        n_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  o;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [3:0]  f;   // {c, v, z, n}
    int          lat;
  } vec_t;

  always #5 clk = ~clk;

  jtkcpu_muldiv #(.W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .start   (start),
    .op      (op),
    .opnd0   (opnd0),
    .opnd1   (opnd1),
    .busy    (busy),
    .done    (done),
    .rslt_hi (rslt_hi),
    .rslt_lo (rslt_lo),
    .c_out   (c_out),
    .v_out   (v_out),
    .z_out   (z_out),
    .n_out   (n_out)
  );

  // Reference: plain integer arithmetic on the architectural definition.
  function automatic void model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] hi, output logic [15:0] lo,
                                output logic [3:0] f, output int lat);
    longint p;
    int q;
    int r;
    lat = 19;
    if (o == MD_MULU || o == MD_MULS) begin
      if (o == MD_MULU) p = longint'(a) * longint'(b);
      else              p = longint'($signed(a)) * longint'($signed(b));
      hi = p[31:16];
      lo = p[15:0];
      f  = {lo[15], 1'b0, (p[31:0] == 32'd0), hi[15]};
    end else if (b == 16'd0) begin
      hi  = a;
      lo  = 16'hFFFF;
      f   = 4'b0101;
      lat = 3;
    end else if (o == MD_DIVS && a == 16'h8000 && b == 16'hFFFF) begin
      hi = 16'h0000;
      lo = 16'h8000;
      f  = 4'b0101;
    end else begin
      if (o == MD_DIVU) begin
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
      end else begin
        q = int'($signed(a)) / int'($signed(b));
        r = int'($signed(a)) % int'($signed(b));
      end
      hi = r[15:0];
      lo = q[15:0];
      f  = {1'b0, 1'b0, (lo == 16'd0), lo[15]};
    end
  endfunction

  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1; op = o; opnd0 = a; opnd1 = b;
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    opnd0 = 16'($urandom);
    opnd1 = 16'($urandom);
  endtask

  // Returns cen-cycle index at which done is seen (cycle 1 = right after acceptance), -1 on timeout.
  task automatic wait_done(output int cyc, output bit busy_bad);
    cyc = 1;
    busy_bad = 1'b0;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
    else if (busy !== 1'b0) busy_bad = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cen = 1'b1; start = 1'b0; op = 2'd0; opnd0 = 16'd0; opnd1 = 16'd0;
    #12;
    checks++;
    if ({busy, done, rslt_hi, rslt_lo, c_out, v_out, z_out, n_out} !== 38'd0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h cvzn=%b%b%b%b, want all 0",
               busy, done, rslt_hi, rslt_lo, c_out, v_out, z_out, n_out);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    vec_t tbl[9];
    int cyc;
    bit bb;
    tbl[0] = '{MD_MULU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 4'b0001, 19};
    tbl[1] = '{MD_MULS, 16'hFFFF, 16'h0002, 16'hFFFF, 16'hFFFE, 4'b1001, 19};
    tbl[2] = '{MD_MULU, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 4'b0010, 19};
    tbl[3] = '{MD_DIVU, 16'd1000, 16'd7,    16'h0006, 16'h008E, 4'b0000, 19};
    tbl[4] = '{MD_DIVS, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 4'b0001, 19};
    tbl[5] = '{MD_DIVU, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 4'b0101, 3};
    tbl[6] = '{MD_DIVS, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 4'b0101, 19};
    tbl[7] = '{MD_DIVS, 16'h0005, 16'hFFFE, 16'h0001, 16'hFFFE, 4'b0001, 19};
    tbl[8] = '{MD_DIVU, 16'h0003, 16'h0007, 16'h0003, 16'h0000, 4'b0010, 19};
    for (int i = 0; i < 9; i++) begin
      issue(tbl[i].o, tbl[i].a, tbl[i].b);
      wait_done(cyc, bb);
      checks++;
      if (cyc != tbl[i].lat || bb) begin
        failures++;
        $display("FAIL directed_latency[%0d]: got done at %0d busy_err=%0d, want %0d busy_err=0",
                 i, cyc, bb, tbl[i].lat);
      end
      checks++;
      if (rslt_hi !== tbl[i].hi || rslt_lo !== tbl[i].lo || {c_out, v_out, z_out, n_out} !== tbl[i].f) begin
        failures++;
        $display("FAIL directed_result[%0d]: got hi=%h lo=%h cvzn=%b, want hi=%h lo=%h cvzn=%b",
                 i, rslt_hi, rslt_lo, {c_out, v_out, z_out, n_out}, tbl[i].hi, tbl[i].lo, tbl[i].f);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [15:0] a, b, ehi, elo;
    logic [3:0]  ef;
    int lat, cyc;
    bit bb;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = 16'd0;
      if ($urandom_range(0, 15) == 0) begin o = MD_DIVS; a = 16'h8000; b = 16'hFFFF; end
      model(o, a, b, ehi, elo, ef, lat);
      issue(o, a, b);
      wait_done(cyc, bb);
      checks++;
      if (cyc != lat || bb || rslt_hi !== ehi || rslt_lo !== elo || {c_out, v_out, z_out, n_out} !== ef) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got lat=%0d busy_err=%0d hi=%h lo=%h cvzn=%b, want lat=%0d hi=%h lo=%h cvzn=%b",
                 i, o, a, b, cyc, bb, rslt_hi, rslt_lo, {c_out, v_out, z_out, n_out}, lat, ehi, elo, ef);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ehi, elo;
    logic [3:0]  ef;
    int lat, cyc;
    bit bb;
    issue(MD_MULU, 16'h00FF, 16'h0101);
    wait_done(cyc, bb);
    // Still in the done cycle: launch the next op immediately.
    start = 1'b1; op = MD_DIVS; opnd0 = 16'hFC18; opnd1 = 16'h0007;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", busy, done);
    end
    model(MD_DIVS, 16'hFC18, 16'h0007, ehi, elo, ef, lat);
    wait_done(cyc, bb);
    checks++;
    if (cyc != 19 || bb || rslt_hi !== ehi || rslt_lo !== elo || {c_out, v_out, z_out, n_out} !== ef) begin
      failures++;
      $display("FAIL b2b_second: got lat=%0d busy_err=%0d hi=%h lo=%h cvzn=%b, want lat=19 hi=%h lo=%h cvzn=%b",
               cyc, bb, rslt_hi, rslt_lo, {c_out, v_out, z_out, n_out}, ehi, elo, ef);
    end
  endtask

  task automatic test_busy_ignore;
    logic [15:0] ehi, elo;
    logic [3:0]  ef;
    int lat, cyc, extra;
    bit bb;
    model(MD_MULU, 16'h1234, 16'h5678, ehi, elo, ef, lat);
    issue(MD_MULU, 16'h1234, 16'h5678);
    repeat (4) @(negedge clk);
    start = 1'b1; op = MD_DIVU; opnd0 = 16'h0005; opnd1 = 16'h0000;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bb);
    if (cyc > 0) cyc += 7;
    checks++;
    if (cyc != 19 || rslt_hi !== ehi || rslt_lo !== elo || {c_out, v_out, z_out, n_out} !== ef) begin
      failures++;
      $display("FAIL busy_ignore: got lat=%0d hi=%h lo=%h cvzn=%b, want lat=19 hi=%h lo=%h cvzn=%b",
               cyc, rslt_hi, rslt_lo, {c_out, v_out, z_out, n_out}, ehi, elo, ef);
    end
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL busy_ignore_no_second_op: got %0d active cycles, want 0", extra);
    end
  endtask

  task automatic test_cen_toggle;
    logic [15:0] a, b, ehi, elo;
    logic [3:0]  ef;
    int lat, first, last, cnt;
    bit both;
    a = 16'($urandom) | 16'h0001;
    b = 16'($urandom) | 16'h0001;
    model(MD_MULU, a, b, ehi, elo, ef, lat);
    @(negedge clk);
    cen = 1'b1; start = 1'b1; op = MD_MULU; opnd0 = a; opnd1 = b;
    @(negedge clk);
    start = 1'b0; cen = 1'b0;
    first = -1; last = -1; cnt = 0; both = 1'b0;
    // k counts clock edges since acceptance; clock cycle k+1 follows edge k.
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (first < 0) first = k + 1;
        last = k + 1;
        cnt++;
        if (busy === 1'b1) both = 1'b1;
      end
      cen = ((k + 1) % 2 == 0);
    end
    cen = 1'b1;
    // cen-cycle 19 spans clock cycles 37 and 38 at one enable per two clocks.
    checks++;
    if (first != 37 || last != 38 || cnt != 2 || both) begin
      failures++;
      $display("FAIL cen_toggle_timing: got done clocks %0d..%0d count=%0d busy_overlap=%0d, want 37..38 count=2 overlap=0",
               first, last, cnt, both);
    end
    checks++;
    if (rslt_hi !== ehi || rslt_lo !== elo || {c_out, v_out, z_out, n_out} !== ef) begin
      failures++;
      $display("FAIL cen_toggle_result: got hi=%h lo=%h cvzn=%b, want hi=%h lo=%h cvzn=%b",
               rslt_hi, rslt_lo, {c_out, v_out, z_out, n_out}, ehi, elo, ef);
    end
  endtask

  task automatic test_reset_midrun;
    logic [15:0] a, b, ehi, elo;
    logic [3:0]  ef;
    int lat, cyc, extra;
    bit bb;
    issue(MD_MULS, 16'hABCD, 16'h1357);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, rslt_hi, rslt_lo, c_out, v_out, z_out, n_out} !== 38'd0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h cvzn=%b%b%b%b, want all 0",
               busy, done, rslt_hi, rslt_lo, c_out, v_out, z_out, n_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL reset_abort: got %0d active cycles after reset, want 0", extra);
    end
    a = 16'($urandom);
    b = 16'($urandom) | 16'h0001;
    model(MD_DIVU, a, b, ehi, elo, ef, lat);
    issue(MD_DIVU, a, b);
    wait_done(cyc, bb);
    checks++;
    if (cyc != 19 || bb || rslt_hi !== ehi || rslt_lo !== elo || {c_out, v_out, z_out, n_out} !== ef) begin
      failures++;
      $display("FAIL post_reset_op: got lat=%0d busy_err=%0d hi=%h lo=%h cvzn=%b, want lat=19 hi=%h lo=%h cvzn=%b",
               cyc, bb, rslt_hi, rslt_lo, {c_out, v_out, z_out, n_out}, ehi, elo, ef);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_cen_toggle();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
